// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, valid/ready handshake and EX forwarding.
// Optional stall counter output perf_stall_cnt is enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage_reg #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [WORD_LEN-1:0]     ex_alu_result,
  input  logic [WORD_LEN-1:0]     ex_store_data,
  input  logic [REG_ADDR_LEN-1:0] ex_dest,
  input  logic                    ex_wb_en,
  input  logic                    ex_mem_r_en,
  input  logic                    ex_mem_w_en,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [WORD_LEN-1:0]     mem_alu_result,
  output logic [WORD_LEN-1:0]     mem_store_data,
  output logic [REG_ADDR_LEN-1:0] mem_dest,
  output logic                    mem_wb_en,
  output logic                    mem_mem_r_en,
  output logic                    mem_mem_w_en,
  output logic                    fwd_valid,
  output logic [REG_ADDR_LEN-1:0] fwd_dest,
  output logic [WORD_LEN-1:0]     fwd_data
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [WORD_LEN-1:0]     alu_result;
    logic [WORD_LEN-1:0]     store_data;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  logic   acc;
  logic   pop;

  assign acc = ex_valid & ex_ready;
  assign pop = mem_valid & mem_ready;

  // $zero is never written back, so its write enable is dropped at capture.
  assign in_entry.alu_result = ex_alu_result;
  assign in_entry.store_data = ex_store_data;
  assign in_entry.dest       = ex_dest;
  assign in_entry.wb_en      = ex_wb_en & (ex_dest != {REG_ADDR_LEN{1'b0}});
  assign in_entry.mem_r_en   = ex_mem_r_en;
  assign in_entry.mem_w_en   = ex_mem_w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      mem_valid <= 1'b0;
      ex_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      mem_valid <= 1'b0;
      ex_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            head      <= in_entry;
            mem_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            head <= in_entry;
          end else if (acc) begin
            skid     <= in_entry;
            ex_ready <= 1'b0;
            state    <= FULL;
          end else if (pop) begin
            mem_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head     <= skid;
            ex_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          mem_valid <= 1'b0;
          ex_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_alu_result = head.alu_result;
  assign mem_store_data = head.store_data;
  assign mem_dest       = head.dest;
  assign mem_wb_en      = head.wb_en;
  assign mem_mem_r_en   = head.mem_r_en;
  assign mem_mem_w_en   = head.mem_w_en;

  // Load results are not available yet, so only non-load writebacks forward.
  assign fwd_valid = mem_valid & head.wb_en & ~head.mem_r_en;
  assign fwd_dest  = head.dest;
  assign fwd_data  = head.alu_result;

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
    end else if (ex_valid && !ex_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Randomized scoreboard bench for ex_mem_stage_reg: a queue model of the buffered
// instructions predicts head contents, ready, forwarding and (optionally) the stall counter.
module tb_ex_mem_stage_reg;
  localparam int W = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_ready;
  logic [W-1:0] ex_alu_result = '0;
  logic [W-1:0] ex_store_data = '0;
  logic [A-1:0] ex_dest = '0;
  logic         ex_wb_en = 1'b0;
  logic         ex_mem_r_en = 1'b0;
  logic         ex_mem_w_en = 1'b0;
  logic         mem_valid;
  logic         mem_ready = 1'b0;
  logic [W-1:0] mem_alu_result;
  logic [W-1:0] mem_store_data;
  logic [A-1:0] mem_dest;
  logic         mem_wb_en;
  logic         mem_mem_r_en;
  logic         mem_mem_w_en;
  logic         fwd_valid;
  logic [A-1:0] fwd_dest;
  logic [W-1:0] fwd_data;
`ifdef EX_MEM_PERF_EN
  logic [31:0]  perf_stall_cnt;
  logic [31:0]  exp_stall = 32'd0;
`endif

  ex_mem_stage_reg #(.WORD_LEN(W), .REG_ADDR_LEN(A)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en), .mem_mem_w_en(mem_mem_w_en),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`ifdef EX_MEM_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] sd;
    logic [A-1:0] dest;
    logic         wb;
    logic         rd;
    logic         wr;
  } instr_t;

  instr_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instructions in flight form a FIFO of capacity two.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
`ifdef EX_MEM_PERF_EN
      exp_stall = 32'd0;
`endif
    end else begin
      automatic bit rdy = (q.size() < 2);
      automatic bit vld = (q.size() > 0);
      automatic instr_t it;
`ifdef EX_MEM_PERF_EN
      if (ex_valid && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (vld && mem_ready) void'(q.pop_front());
        if (ex_valid && rdy) begin
          it.alu  = ex_alu_result;
          it.sd   = ex_store_data;
          it.dest = ex_dest;
          it.wb   = ex_wb_en && (ex_dest != 5'd0);
          it.rd   = ex_mem_r_en;
          it.wr   = ex_mem_w_en;
          q.push_back(it);
        end
      end
    end
  end

  // Monitor: compare the presented head and handshake against the model mid-cycle.
  always @(negedge clk) begin
    chk("mem_valid", {63'd0, mem_valid}, {63'd0, q.size() > 0});
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("mem_alu_result", {32'd0, mem_alu_result}, {32'd0, q[0].alu});
      chk("mem_store_data", {32'd0, mem_store_data}, {32'd0, q[0].sd});
      chk("mem_dest", {59'd0, mem_dest}, {59'd0, q[0].dest});
      chk("mem_ctrl", {61'd0, mem_wb_en, mem_mem_r_en, mem_mem_w_en},
          {61'd0, q[0].wb, q[0].rd, q[0].wr});
      chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, q[0].wb && !q[0].rd});
      if (q[0].wb && !q[0].rd) begin
        chk("fwd_dest", {59'd0, fwd_dest}, {59'd0, q[0].dest});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, q[0].alu});
      end
    end else begin
      chk("fwd_valid_empty", {63'd0, fwd_valid}, 64'd0);
    end
`ifdef EX_MEM_PERF_EN
    chk("perf_stall_cnt", {32'd0, perf_stall_cnt}, {32'd0, exp_stall});
`endif
  end

  task automatic cyc(input bit v, input logic [W-1:0] alu, input logic [A-1:0] d,
                     input bit wb, input bit rd, input bit rdy, input bit fl);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_store_data = $urandom;
    ex_dest       = d;
    ex_wb_en      = wb;
    ex_mem_r_en   = rd;
    ex_mem_w_en   = ~rd & ~wb;
    mem_ready     = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming 1..8 with MEM always ready.
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: A, B fill the buffer, C is held until release.
    cyc(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'hC, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i == 0, 32'hC, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush while FULL with a pending instruction.
    cyc(1'b1, 32'h33, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Forwarding: ALU op, load, and a write to $zero.
    cyc(1'b1, 32'hA, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hB, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized phases with varying MEM back-pressure and occasional flushes.
    for (int p = 0; p < 12; p++) begin
      automatic int rdy_pct = (p % 4 == 0) ? 0 : (p % 4 == 1) ? 30 : (p % 4 == 2) ? 70 : 100;
      for (int i = 0; i < 200; i++) begin
        automatic logic [A-1:0] d = ($urandom_range(0, 3) == 0) ? 5'd0 : A'($urandom_range(1, 31));
        cyc($urandom_range(0, 99) < 70, $urandom, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < 4);
      end
    end

    // Asynchronous reset mid-run while the buffer holds data.
    cyc(1'b1, 32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h88, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_data", {mem_alu_result, mem_store_data}, 64'd0);
    chk("rst_ctrl", {56'd0, mem_dest, mem_wb_en, mem_mem_r_en, mem_mem_w_en}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Drain and confirm everything was delivered.
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drained", {32'd0, q.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule
